mux_ctrl_rr: RTL and testbench
==============================

// Module: mux_ctrl_rr
// PURPOSE
//  Per-output write-mux controller for the shared-cache switch, successor to the fixed-priority mux controller.
//  For each of N output queues, arbitrates among N input ports round-robin with packet locking.
//  Drives mux select, queue write enable, and a per-(input,output) grant back to the inputs.
//  Sits between input-port request logic and the shared-memory write muxes/queues.
// PARAMETERS
//  N        `PORT_NUB_TOTAL   number of ports (inputs = outputs), >=2
//  SEL_W    $clog2(N)         localparam, width of one select field
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        asynchronous, active-low reset
//  port_valid  in   N*N      bit j*N+i: input j has a beat for output i
//  port_last   in   N        bit j: input j's current beat is the last of its packet
//  full_in     in   N        bit i: output queue i cannot accept a write this cycle
//  grant_out   out  N*N      bit j*N+i: output i accepts input j's beat this cycle
//  wr_en_out   out  N        bit i: write output queue i
//  mux_sel     out  N*SEL_W  field i: input index routed to output i
// BEHAVIOUR
//  - Clock clk; reset rst_n, asynchronous, active-low.
//  - Reset values:
//    - all outputs 0; every output FSM in IDLE.
//    - ptr[i] = N-1, so input 0 wins first.
//    - owner[i] = 0.
//  - Per-output FSM, two states: IDLE, LOCK.
//  - IDLE: win = first j with valid[j][i], searching from ptr[i]+1 mod N.
//    - If any request and !full_in[i]: grant win; wr_en[i] = 1; sel[i] = win.
//    - If port_last[win] = 0: go to LOCK with owner[i] = win.
//    - Otherwise: ptr[i] = win and stay in IDLE (single-beat packet).
//  - LOCK: only owner[i] may be granted; sel[i] = owner[i] the whole time.
//    - A beat transfers when valid[owner][i] & !full_in[i].
//    - On a beat with port_last[owner] = 1: go to IDLE and set ptr[i] = owner.
//  - Transfer rule: a beat moves when valid and grant are high in the same cycle.
//    - The input holds valid and data stable until it is granted.
//  - full_in[i] = 1: no grant and wr_en[i] = 0; FSM and ptr unchanged. Back-pressure is per output, not global.
//  - Owner drops valid while in LOCK: bubble with wr_en = 0. The lock is held and other inputs stay blocked.
//  - Outputs are fully independent. An input requesting several outputs (multicast) may be granted by each separately.
//    - The input holds its data until every requested output has granted.
//  - IDLE with no request: sel[i] holds its last value; wr_en = 0.
//  - At most one grant bit per output column per cycle. wr_en_out[i] == |grant column i.
//  - Reset mid-packet: all locks are dropped immediately. The requester must restart the packet.
// CONFIGURATION
//  - Macro: MUX_CTRL_REG_OUT_EN
//  - Defined:
//    - wr_en_out and mux_sel are registered: 1-cycle latency after the grant.
//    - grant_out stays combinational, so the input handshake is unchanged.
//    - Registered outputs reset to 0.
//  - Undefined: wr_en_out, mux_sel and grant_out are combinational from inputs and state (0 latency).
// STRUCTURE
//  - Shared header generate_parameter.vh holds:
//    - `PORT_NUB_TOTAL
//    - FSM state encodings MUX_ST_IDLE = 1'b0, MUX_ST_LOCK = 1'b1
//  - Sub-module rr_arbiter (N requests, SEL_W pointer in -> one-hot grant + index out). Instantiated once per output in a generate loop.
//  - Top level holds: column transpose of port_valid, per-output FSM, ptr/owner registers, output mux/register.
// TESTING  (N=4)
//  - After reset: valid col0 = 4'b1111, last = 4'b1111, full = 0.
//    -> grants to inputs 0,1,2,3,0 on consecutive cycles; mux_sel[0] = 0,1,2,3,0.
//  - Input 2 sends a 3-beat packet to out 1 (last on beat 3); input 0 requests out 1 from cycle 1.
//    -> input 0 is not granted until the cycle after input 2's last beat.
//  - full_in[3] = 1 for 5 cycles with requests pending.
//    -> wr_en_out[3] = 0 and no column-3 grant.
//    -> on release, the winner is the same input that would have won before.
//  - Owner drops valid for 2 cycles mid-packet.
//    -> wr_en = 0 for those cycles; other requesters stay ungranted; lock resumes.
//  - Input 1 requests outs 0 and 2 simultaneously with no contention.
//    -> grant bits 1*4+0 and 1*4+2 both high in the same cycle.
//  - Assert rst_n = 0 during LOCK.
//    -> next cycle: all outputs 0, ptr = 3; a new request from input 3 is granted.
//    -> with MUX_CTRL_REG_OUT_EN, wr_en/mux_sel lag the grants by 1 cycle in all tests.

Source files
------------

// File: rtl/mux_ctrl_rr_pkg.sv
// Shared definitions for the round-robin write-mux controller: port count and per-output FSM states.
package mux_ctrl_rr_pkg;

   localparam int unsigned PORT_NUB_TOTAL = 4;

   typedef enum logic {
      MUX_ST_IDLE = 1'b0,
      MUX_ST_LOCK = 1'b1
   } mux_st_e;

endpackage

// File: rtl/mux_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first request after i_ptr (wrapping) and returns it one-hot and as an index.
module rr_arbiter
   import mux_ctrl_rr_pkg::*;
#(
   parameter int unsigned N     = PORT_NUB_TOTAL,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_any
);

   logic [SEL_W-1:0] w_j;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = '0;
      // k = N lands back on i_ptr itself, so the last holder is searched last
      for (int unsigned k = 1; k <= N; k++) begin
         w_j = SEL_W'((32'(i_ptr) + k) % N);
         if (!o_any && i_req[w_j]) begin
            o_any      = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
         end
      end
   end

endmodule

// File: rtl/mux_ctrl_rr.sv
// Per-output round-robin write-mux controller with packet locking.
// Optional MUX_CTRL_REG_OUT_EN registers wr_en_out/mux_sel; grant_out always stays combinational.
module mux_ctrl_rr
   import mux_ctrl_rr_pkg::*;
#(
   parameter int unsigned N = PORT_NUB_TOTAL
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N*N-1:0]             port_valid,
   input  logic [N-1:0]               port_last,
   input  logic [N-1:0]               full_in,
   output logic [N*N-1:0]             grant_out,
   output logic [N-1:0]               wr_en_out,
   output logic [N*$clog2(N)-1:0]     mux_sel
);

   localparam int unsigned SEL_W = $clog2(N);

   for (genvar gi = 0; gi < N; gi++) begin : g_out
      mux_st_e          r_state, w_nxt_state;
      logic [SEL_W-1:0] r_ptr, w_nxt_ptr;
      logic [SEL_W-1:0] r_owner, w_nxt_owner;
      logic [SEL_W-1:0] r_sel_last, w_sel, w_win_idx;
      logic [N-1:0]     w_col, w_win_oh, w_gnt;
      logic             w_any, w_wr;

      for (genvar gj = 0; gj < N; gj++) begin : g_col
         assign w_col[gj]             = port_valid[gj*N+gi];
         assign grant_out[gj*N+gi]    = w_gnt[gj];
      end

      rr_arbiter #(
         .N     (N),
         .SEL_W (SEL_W)
      ) u_arb (
         .i_req (w_col),
         .i_ptr (r_ptr),
         .o_gnt (w_win_oh),
         .o_idx (w_win_idx),
         .o_any (w_any)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state    <= MUX_ST_IDLE;
            r_ptr      <= SEL_W'(N-1);
            r_owner    <= '0;
            r_sel_last <= '0;
         end else begin
            r_state    <= w_nxt_state;
            r_ptr      <= w_nxt_ptr;
            r_owner    <= w_nxt_owner;
            r_sel_last <= w_sel;
         end
      end

      always_comb begin
         w_nxt_state = r_state;
         w_nxt_ptr   = r_ptr;
         w_nxt_owner = r_owner;
         w_gnt       = '0;
         w_wr        = 1'b0;
         w_sel       = r_sel_last;
         // Outputs are held quiet while reset is asserted, even with requests pending
         if (rst_n) begin
            case (r_state)
               MUX_ST_IDLE: begin
                  if (w_any && !full_in[gi]) begin
                     w_gnt = w_win_oh;
                     w_wr  = 1'b1;
                     w_sel = w_win_idx;
                     if (!port_last[w_win_idx]) begin
                        w_nxt_state = MUX_ST_LOCK;
                        w_nxt_owner = w_win_idx;
                     end else begin
                        w_nxt_ptr = w_win_idx;
                     end
                  end
               end
               MUX_ST_LOCK: begin
                  w_sel = r_owner;
                  if (w_col[r_owner] && !full_in[gi]) begin
                     w_gnt[r_owner] = 1'b1;
                     w_wr           = 1'b1;
                     if (port_last[r_owner]) begin
                        w_nxt_state = MUX_ST_IDLE;
                        w_nxt_ptr   = r_owner;
                     end
                  end
               end
            endcase
         end
      end

`ifdef MUX_CTRL_REG_OUT_EN
      logic             r_wr;
      logic [SEL_W-1:0] r_sel;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wr  <= 1'b0;
            r_sel <= '0;
         end else begin
            r_wr  <= w_wr;
            r_sel <= w_sel;
         end
      end

      assign wr_en_out[gi]                 = r_wr;
      assign mux_sel[gi*SEL_W +: SEL_W]    = r_sel;
`else
      assign wr_en_out[gi]                 = w_wr;
      assign mux_sel[gi*SEL_W +: SEL_W]    = w_sel;
`endif
   end

endmodule

// File: tb/tb_mux_ctrl_rr.sv
// Directed bench for mux_ctrl_rr (N=4): round-robin order, locking, back-pressure, bubbles, multicast, reset.
module tb_mux_ctrl_rr;

   logic        clk;
   logic        rst_n;
   logic [15:0] port_valid;
   logic [3:0]  port_last;
   logic [3:0]  full_in;
   logic [15:0] grant_out;
   logic [3:0]  wr_en_out;
   logic [7:0]  mux_sel;

   int unsigned n_chk;
   int unsigned n_pass;
   logic [3:0]  pw;
   logic [7:0]  ps;
   logic [7:0]  es;

   mux_ctrl_rr #(.N(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .port_valid (port_valid),
      .port_last  (port_last),
      .full_in    (full_in),
      .grant_out  (grant_out),
      .wr_en_out  (wr_en_out),
      .mux_sel    (mux_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock cycle: check at the falling edge, then step past the rising edge.
   task automatic cyc(input string tag, input logic [15:0] eg, input logic [3:0] ew, input logic [7:0] esl);
      logic [3:0] xw;
      logic [7:0] xs;
`ifdef MUX_CTRL_REG_OUT_EN
      xw = pw;
      xs = ps;
      pw = ew;
      ps = esl;
`else
      xw = ew;
      xs = esl;
`endif
      @(negedge clk);
      chk({tag, " grant"}, grant_out, eg);
      chk({tag, " wr_en"}, {12'h0, wr_en_out}, {12'h0, xw});
      chk({tag, " sel"}, {8'h0, mux_sel}, {8'h0, xs});
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      pw         = '0;
      ps         = '0;
      es         = '0;
      rst_n      = 1'b0;
      port_valid = '0;
      port_last  = '0;
      full_in    = '0;
      #3;
      cyc("reset", 16'h0000, 4'b0000, 8'h00);
      rst_n = 1'b1;

      // All four inputs on output 0, single-beat packets
      port_valid = 16'h1111;
      port_last  = 4'b1111;
      es[1:0] = 2'd0; cyc("rr0_in0", 16'h0001, 4'b0001, es);
      es[1:0] = 2'd1; cyc("rr0_in1", 16'h0010, 4'b0001, es);
      es[1:0] = 2'd2; cyc("rr0_in2", 16'h0100, 4'b0001, es);
      es[1:0] = 2'd3; cyc("rr0_in3", 16'h1000, 4'b0001, es);
      es[1:0] = 2'd0; cyc("rr0_wrap", 16'h0001, 4'b0001, es);
      port_valid = '0;
      cyc("idle_hold", 16'h0000, 4'b0000, es);

      // Input 2 locks output 1 for three beats; input 0 waits
      port_valid = 16'h0200;
      port_last  = 4'b1011;
      es[3:2] = 2'd2; cyc("lock_b1", 16'h0200, 4'b0010, es);
      port_valid = 16'h0202;
      cyc("lock_b2", 16'h0200, 4'b0010, es);
      port_last  = 4'b1111;
      cyc("lock_b3", 16'h0200, 4'b0010, es);
      port_valid = 16'h0002;
      es[3:2] = 2'd0; cyc("after_lock", 16'h0002, 4'b0010, es);
      port_valid = '0;
      cyc("idle2", 16'h0000, 4'b0000, es);

      // Output 3 back-pressured for 5 cycles with inputs 1 and 2 pending
      port_valid = 16'h0880;
      full_in    = 4'b1000;
      for (int i = 0; i < 5; i++) cyc("full3", 16'h0000, 4'b0000, es);
      full_in = '0;
      es[7:6] = 2'd1; cyc("full_rel", 16'h0080, 4'b1000, es);
      port_valid = 16'h0800;
      es[7:6] = 2'd2; cyc("full_next", 16'h0800, 4'b1000, es);
      port_valid = '0;

      // Input 0 locks output 2, drops valid for two cycles while input 1 waits
      port_valid = 16'h0044;
      port_last  = 4'b1110;
      es[5:4] = 2'd0; cyc("bub_b1", 16'h0004, 4'b0100, es);
      port_valid = 16'h0040;
      cyc("bub_gap1", 16'h0000, 4'b0000, es);
      cyc("bub_gap2", 16'h0000, 4'b0000, es);
      port_valid = 16'h0044;
      cyc("bub_b2", 16'h0004, 4'b0100, es);
      port_last  = 4'b1111;
      cyc("bub_b3", 16'h0004, 4'b0100, es);
      port_valid = 16'h0040;
      es[5:4] = 2'd1; cyc("bub_next", 16'h0040, 4'b0100, es);
      port_valid = '0;

      // Input 1 multicasts to outputs 0 and 2
      port_valid = 16'h0050;
      es[1:0] = 2'd1; es[5:4] = 2'd1; cyc("mcast", 16'h0050, 4'b0101, es);
      port_valid = '0;
      cyc("idle3", 16'h0000, 4'b0000, es);

      // Input 3 locks output 3, then reset mid-packet
      port_valid = 16'h8000;
      port_last  = 4'b0111;
      es[7:6] = 2'd3; cyc("pre_rst", 16'h8000, 4'b1000, es);
      rst_n = 1'b0;
      pw = '0;
      ps = '0;
      es = '0;
      cyc("rst_lock", 16'h0000, 4'b0000, es);
      rst_n     = 1'b1;
      port_last = 4'b1111;
      es[7:6] = 2'd3; cyc("post_rst", 16'h8000, 4'b1000, es);
      port_valid = '0;
      cyc("final_idle", 16'h0000, 4'b0000, es);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
